// File: rtl/clock_disp_pkg.sv
// Shared constants and types for the clock display scanner: active-low segment
// patterns, blink field encodings and the legal range of each time field.
package clock_disp_pkg;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    BLINK_NONE = 2'd0,
    BLINK_SEC  = 2'd1,
    BLINK_MIN  = 2'd2,
    BLINK_HR   = 2'd3
  } blink_sel_e;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

endpackage

// File: rtl/clock_disp_scan_seg7_dec.sv
// Combinational decimal digit to active-low seven-segment pattern.
module seg7_dec
  import clock_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_disp_scan.sv
// Captures hh:mm:ss atomically on upd and scans the six digits onto a
// multiplexed common-anode display with blinking colon and optional field blink.
module clock_disp_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hr,
  input  logic       upd,
  input  logic [1:0] blink_sel,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       bad
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  // Tens/ones of a value below 60 via a descending compare/subtract ladder.
  function automatic bcd_t split_bcd(input logic [5:0] v);
    bcd_t r;
    if (v >= 6'd50) begin
      r.tens = 4'd5; r.ones = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      r.tens = 4'd4; r.ones = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      r.tens = 4'd3; r.ones = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      r.tens = 4'd2; r.ones = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      r.tens = 4'd1; r.ones = 4'(v - 6'd10);
    end else begin
      r.tens = 4'd0; r.ones = v[3:0];
    end
    return r;
  endfunction

  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hr_q, hr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          bad_q, bad_d;

  logic          upd_ok;
  logic          presc_wrap;
  logic          idx_wrap;
  bcd_t          sec_bcd, min_bcd, hr_bcd;
  logic [3:0]    digit;
  logic [6:0]    dec_seg;
  logic [1:0]    idx_field;
  logic          blink_hit;

  // A strobe with any out-of-range field is dropped whole so the shadow never
  // holds a mixed old/new time.
  always_comb begin
    upd_ok = (sec <= SEC_MAX) && (min <= MIN_MAX) && (hr <= HR_MAX);
    sec_d  = sec_q;
    min_d  = min_q;
    hr_d   = hr_q;
    if (upd && upd_ok) begin
      sec_d = sec;
      min_d = min;
      hr_d  = hr;
    end
    bad_d = upd && !upd_ok;
  end

  always_comb begin
    presc_wrap = (presc_q == PRESC_LAST);
    idx_wrap   = presc_wrap && (idx_q == 3'd5);
    presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    idx_d      = idx_q;
    if (presc_wrap) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
    frame_d = frame_q;
    phase_d = phase_q;
    if (idx_wrap) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_comb begin
    sec_bcd = split_bcd(sec_q);
    min_bcd = split_bcd(min_q);
    hr_bcd  = split_bcd({1'b0, hr_q});
    case (idx_q)
      3'd0:    digit = sec_bcd.ones;
      3'd1:    digit = sec_bcd.tens;
      3'd2:    digit = min_bcd.ones;
      3'd3:    digit = min_bcd.tens;
      3'd4:    digit = hr_bcd.ones;
      3'd5:    digit = hr_bcd.tens;
      default: digit = 4'hF;
    endcase
  end

  seg7_dec u_dec (
    .digit (digit),
    .seg   (dec_seg)
  );

  // Digit pairs map onto blink_sel codes 1..3 (sec, min, hr).
  always_comb begin
    idx_field = 2'(idx_q[2:1] + 2'd1);
    blink_hit = phase_q && (blink_sel != BLINK_NONE) && (blink_sel == idx_field);
    an_d      = (presc_q == '0) ? 6'h3F : ~(6'd1 << idx_q);
    seg_d     = blink_hit ? SEG_BLANK : dec_seg;
    dp_d      = !(((idx_q == 3'd2) || (idx_q == 3'd4)) && !phase_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
      an_q    <= 6'h3F;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      bad_q   <= 1'b0;
    end else begin
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      bad_q   <= bad_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;
  assign bad = bad_q;

endmodule

// File: tb/tb_clock_disp_scan.sv
// Bench for clock_disp_scan: a cycle-count based reference model predicts every
// output; scenario tasks drive stimulus and compare inline.
module tb_clock_disp_scan;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] sec = '0;
  logic [5:0] min = '0;
  logic [4:0] hr = '0;
  logic       upd = 1'b0;
  logic [1:0] blink_sel = '0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       bad;

  int vectors = 0;
  int miscompares = 0;

  clock_disp_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sec       (sec),
    .min       (min),
    .hr        (hr),
    .upd       (upd),
    .blink_sel (blink_sel),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .bad       (bad)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_k;
  int          m_sec, m_min, m_hr;
  logic [13:0] exp_vec;
  logic        exp_bad;

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // k = clock edges since reset release; everything follows from it.
  function automatic logic [13:0] ref_out(input int k, input int s, input int m,
                                          input int h, input int bsel);
    int presc, slot, idx, phase, d;
    logic [5:0] a;
    logic [6:0] sg;
    logic       p;
    int digits[6];
    presc = k % SCAN_DIV;
    slot  = k / SCAN_DIV;
    idx   = slot % 6;
    phase = (slot / 6 / BLINK_DIV) % 2;
    digits[0] = s % 10; digits[1] = s / 10;
    digits[2] = m % 10; digits[3] = m / 10;
    digits[4] = h % 10; digits[5] = h / 10;
    d = digits[idx];
    a = 6'h3F;
    if (presc != 0) a[idx] = 1'b0;
    if (phase == 1 && bsel != 0 && bsel == idx / 2 + 1) sg = 7'h7F;
    else sg = ref_seg(d);
    p = (phase == 0 && (idx == 2 || idx == 4)) ? 1'b0 : 1'b1;
    return {a, sg, p};
  endfunction

  function automatic logic in_range(input int s, input int m, input int h);
    return (s < 60) && (m < 60) && (h < 24);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_k     <= 0;
      m_sec   <= 0;
      m_min   <= 0;
      m_hr    <= 0;
      exp_vec <= {6'h3F, 7'h7F, 1'b1};
      exp_bad <= 1'b0;
    end else begin
      exp_vec <= ref_out(m_k, m_sec, m_min, m_hr, int'(blink_sel));
      exp_bad <= upd && !in_range(int'(sec), int'(min), int'(hr));
      if (upd && in_range(int'(sec), int'(min), int'(hr))) begin
        m_sec <= int'(sec);
        m_min <= int'(min);
        m_hr  <= int'(hr);
      end
      m_k <= m_k + 1;
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    upd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({an, seg, dp, bad} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL reset cyc %0d: got an=%b seg=%h dp=%b bad=%b, want an=111111 seg=7f dp=1 bad=0",
                 i, an, seg, dp, bad);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_scan_zero();
    for (int i = 0; i < 2 * 6 * SCAN_DIV + 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({an, seg, dp, bad} !== {exp_vec, exp_bad}) begin
        miscompares++;
        $display("FAIL scan_zero cyc %0d: got %b_%h_%b_%b want %b_%h_%b_%b",
                 i, an, seg, dp, bad, exp_vec[13:8], exp_vec[7:1], exp_vec[0], exp_bad);
      end
    end
  endtask

  task automatic test_capture();
    sec = 6'd9; min = 6'd45; hr = 5'd23; upd = 1'b1;
    @(posedge clk); #1;
    upd = 1'b0;
    for (int i = 0; i < 6 * SCAN_DIV + 6; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({an, seg, dp, bad} !== {exp_vec, exp_bad}) begin
        miscompares++;
        $display("FAIL capture cyc %0d: got %b_%h_%b_%b want %b_%h_%b_%b",
                 i, an, seg, dp, bad, exp_vec[13:8], exp_vec[7:1], exp_vec[0], exp_bad);
      end
      if (an == 6'b111110 && seg !== 7'h10) begin
        vectors++;
        miscompares++;
        $display("FAIL capture_sec_ones: got seg=%h want 10", seg);
      end
      if (an == 6'b011111 && seg !== 7'h24) begin
        vectors++;
        miscompares++;
        $display("FAIL capture_hr_tens: got seg=%h want 24", seg);
      end
    end
  endtask

  task automatic test_bad();
    sec = 6'd1; min = 6'd60; hr = 5'd1; upd = 1'b1;
    @(posedge clk); #1;
    upd = 1'b0;
    vectors++;
    if (bad !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_pulse: got bad=%b want 1", bad);
    end
    @(posedge clk); #1;
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_single: got bad=%b want 0", bad);
    end
    for (int i = 0; i < 6 * SCAN_DIV; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({an, seg, dp, bad} !== {exp_vec, exp_bad}) begin
        miscompares++;
        $display("FAIL bad_hold cyc %0d: got %b_%h_%b_%b want %b_%h_%b_%b",
                 i, an, seg, dp, bad, exp_vec[13:8], exp_vec[7:1], exp_vec[0], exp_bad);
      end
    end
  endtask

  task automatic test_blink();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sec = 6'd37; min = 6'd58; hr = 5'd12; upd = 1'b1;
    @(posedge clk); #1;
    upd = 1'b0;
    blink_sel = 2'd2;
    for (int i = 0; i < 6 * 6 * SCAN_DIV + 8; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({an, seg, dp, bad} !== {exp_vec, exp_bad}) begin
        miscompares++;
        $display("FAIL blink cyc %0d: got %b_%h_%b_%b want %b_%h_%b_%b",
                 i, an, seg, dp, bad, exp_vec[13:8], exp_vec[7:1], exp_vec[0], exp_bad);
      end
    end
    blink_sel = 2'd0;
  endtask

  task automatic test_rst_upd();
    rst = 1'b1; upd = 1'b1;
    sec = 6'd33; min = 6'd22; hr = 5'd11;
    @(posedge clk); #1;
    rst = 1'b0; upd = 1'b0;
    vectors++;
    if (an !== 6'h3F) begin
      miscompares++;
      $display("FAIL rst_upd_an: got an=%b want 111111", an);
    end
    for (int i = 0; i < 6 * SCAN_DIV + 2; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({an, seg, dp, bad} !== {exp_vec, exp_bad}) begin
        miscompares++;
        $display("FAIL rst_upd cyc %0d: got %b_%h_%b_%b want %b_%h_%b_%b",
                 i, an, seg, dp, bad, exp_vec[13:8], exp_vec[7:1], exp_vec[0], exp_bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    sec = 6'd12; min = 6'd34; hr = 5'd5; upd = 1'b1;
    @(posedge clk); #1;
    sec = 6'd48; min = 6'd7; hr = 5'd19;
    @(posedge clk); #1;
    upd = 1'b0;
    for (int i = 0; i < 6 * SCAN_DIV + 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({an, seg, dp, bad} !== {exp_vec, exp_bad}) begin
        miscompares++;
        $display("FAIL back_to_back cyc %0d: got %b_%h_%b_%b want %b_%h_%b_%b",
                 i, an, seg, dp, bad, exp_vec[13:8], exp_vec[7:1], exp_vec[0], exp_bad);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      upd = ($urandom_range(0, 3) == 0);
      sec = 6'($urandom_range(0, 63));
      min = 6'($urandom_range(0, 63));
      hr  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) blink_sel = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      vectors++;
      if ({an, seg, dp, bad} !== {exp_vec, exp_bad}) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %b_%h_%b_%b want %b_%h_%b_%b",
                 i, an, seg, dp, bad, exp_vec[13:8], exp_vec[7:1], exp_vec[0], exp_bad);
      end
    end
    rst = 1'b0;
    upd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_zero();
    test_capture();
    test_bad();
    test_blink();
    test_rst_upd();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_disp_scan.md
Name: clock_disp_scan

Overview:
- Display-side consumer of the digital-clock time counters.
- Atomically captures hour/minute/second values on an update strobe.
- Converts each field to two decimal digits and time-multiplexes them onto a 6-digit common-anode seven-segment display.
- Colon dots blink; one selectable field can blink for set-mode feedback. Sits between the clock core and the board display pins.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot; must be ≥ 2.
- BLINK_DIV, 125: completed 6-digit frames per blink half-period; must be ≥ 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sec  in  6  seconds, binary 0..59
- min  in  6  minutes, binary 0..59
- hr  in  5  hours, binary 0..23
- upd  in  1  one-cycle strobe: capture sec/min/hr
- blink_sel  in  2  0 = none, 1 = sec, 2 = min, 3 = hr field blinks
- an  out  6  digit enables, active-low; an[0] = sec ones … an[5] = hr tens
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low (colon)
- bad  out  1  one-cycle pulse: rejected update

Behaviour:
- Reset (rst = 1 at a clk edge):
  - an = 6'b111111, seg = 7'h7F, dp = 1, bad = 0.
  - Shadow sec/min/hr = 0.
  - Prescaler = 0, digit index = 0, frame counter = 0, blink phase = 0 (visible).
  - rst overrides upd in the same cycle.
- Capture:
  - On upd = 1, all three fields are checked. If sec ≤ 59, min ≤ 59 and hr ≤ 23, all three shadows load in that same edge (atomic).
  - Otherwise no shadow changes and bad = 1 on the next cycle only.
  - upd is accepted every cycle with no busy state. Back-to-back strobes each capture.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index increments 0→1→…→5→0.
- Frame counter:
  - Increments when index wraps 5→0.
  - On reaching BLINK_DIV-1 with a wrap, it resets to 0 and blink phase toggles.
- Digit mapping:
  - idx0 = sec%10, idx1 = sec/10, idx2 = min%10, idx3 = min/10, idx4 = hr%10, idx5 = hr/10.
  - No leading-zero suppression.
- Outputs (all registered; computed from the current index, prescaler and shadow):
  - Blanking slot: when prescaler = 0, an = all 1 (anti-ghosting). Otherwise an = ~(1 << idx).
  - seg = pattern(digit), or 7'h7F when blink phase = 1 and idx lies in the field chosen by blink_sel.
  - dp = 0 when idx ∈ {2,4} and blink phase = 0; otherwise 1.
- Latency:
  - upd at edge N updates the shadow at N.
  - seg reflects the new value at edge N+1 if that digit is active.
- Mid-slot update: the pattern changes immediately within the slot. This is allowed.
- blink_sel changes take effect on the next output register update. The phase does not restart.
- Reset mid-frame returns to idx 0 with the display blank for one cycle.
- Digit values outside 0..9 cannot occur. The decoder default is still 7'h7F.

Decomposition:
- Package clock_disp_pkg holds:
  - SEG_0..SEG_9 active-low constants
  - SEG_BLANK = 7'h7F
  - blink_sel encodings BLINK_NONE/SEC/MIN/HR
  - field limits SEC_MAX = 59, MIN_MAX = 59, HR_MAX = 23
- Sub-module seg7_dec: combinational 4-bit digit → 7-bit active-low pattern, instantiated once on the muxed digit.
- Tens/ones split is done in the top block by constant compare/subtract (value < 60).

Test Plan (SCAN_DIV = 4, BLINK_DIV = 2):
- Reset held 3 cycles, then released with no upd → an cycles 111111, 111110 ×3, then 111111, 111101 ×3 …; seg = 7'h40 ("0") while enabled; dp = 0 during idx2/idx4.
- upd with hr = 23, min = 45, sec = 9 → over one frame the digits read idx0..5 = 9,0,5,4,3,2; seg for idx0 = 7'h10 and idx5 = 7'h24.
- upd with min = 60 (sec = 1, hr = 1) → shadow unchanged; bad = 1 for exactly one cycle after the strobe.
- blink_sel = 2 → idx2/idx3 show 7'h7F during frames 2–3 and visible during frames 0–1 and 4–5; dp is off over the same frames.
- rst and upd asserted together → shadow stays 0; an = 111111 the next cycle.
- upd on consecutive cycles with values A then B → the display shows B; no bad pulse.
